// File: rtl/pixel_pkg.sv
// Shared pixel-path constants: BT.601 luma coefficients, output mode encodings and
// the display/search-window origins that marker offsets are built from.
package pixel_pkg;

  localparam int LUMA_CR    = 77;
  localparam int LUMA_CG    = 150;
  localparam int LUMA_CB    = 29;
  localparam int LUMA_SHIFT = 8;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_GRAY = 2'd1,
    MODE_BIN  = 2'd2,
    MODE_INV  = 2'd3
  } mode_e;

  localparam int DISP_H_START = 144;
  localparam int DISP_V_START = 35;
  localparam int SEARCH_MID_X = 320;
  localparam int SEARCH_MID_Y = 240;

  // Typical marker offsets: active-video start plus the middle of the search window.
  localparam int MARK_H_OFFSET = DISP_H_START + SEARCH_MID_X;
  localparam int MARK_V_OFFSET = DISP_V_START + SEARCH_MID_Y;

endpackage

// File: rtl/luma_calc.sv
// Two-stage BT.601 luma: products registered, then sum/shift/saturate registered.
// Latency 2 cycles, one pixel per cycle, no backpressure; data holds while valid is low.
module luma_calc
  import pixel_pkg::*;
#(
  parameter int DW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_vld,
  input  logic [DW-1:0] in_red,
  input  logic [DW-1:0] in_green,
  input  logic [DW-1:0] in_blue,
  output logic          out_vld,
  output logic [DW-1:0] out_luma
);

  localparam int PRW = DW + 9;

  logic           vld1_q, vld2_q;
  logic [PRW-1:0] prod_r_q, prod_r_d;
  logic [PRW-1:0] prod_g_q, prod_g_d;
  logic [PRW-1:0] prod_b_q, prod_b_d;
  logic [DW-1:0]  luma_q, luma_d;
  logic [PRW-1:0] sum, shifted;

  always_comb begin
    prod_r_d = prod_r_q;
    prod_g_d = prod_g_q;
    prod_b_d = prod_b_q;
    if (in_vld) begin
      prod_r_d = PRW'(LUMA_CR) * PRW'(in_red);
      prod_g_d = PRW'(LUMA_CG) * PRW'(in_green);
      prod_b_d = PRW'(LUMA_CB) * PRW'(in_blue);
    end
  end

  assign sum     = prod_r_q + prod_g_q + prod_b_q;
  assign shifted = sum >> LUMA_SHIFT;

  always_comb begin
    luma_d = luma_q;
    if (vld1_q) begin
      // Any bit above DW means the result would not fit: clamp to full scale.
      if (|shifted[PRW-1:DW]) luma_d = '1;
      else                    luma_d = shifted[DW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld1_q   <= 1'b0;
      vld2_q   <= 1'b0;
      prod_r_q <= '0;
      prod_g_q <= '0;
      prod_b_q <= '0;
      luma_q   <= '0;
    end else begin
      vld1_q   <= in_vld;
      vld2_q   <= vld1_q;
      prod_r_q <= prod_r_d;
      prod_g_q <= prod_g_d;
      prod_b_q <= prod_b_d;
      luma_q   <= luma_d;
    end
  end

  assign out_vld  = vld2_q;
  assign out_luma = luma_q;

endmodule

// File: rtl/pixel_luma_overlay.sv
// Luma conversion with pass/gray/threshold/invert modes and a per-frame latched square marker.
// Latency 3 cycles, one pixel per cycle, no backpressure; outputs hold the last valid pixel.
module pixel_luma_overlay
  import pixel_pkg::*;
#(
  parameter int            DW          = 10,
  parameter int            PW          = 13,
  parameter int            SQUARE_SIZE = 5,
  parameter int            H_OFFSET    = 0,
  parameter int            V_OFFSET    = 0,
  parameter logic [DW-1:0] MARK_R      = '1,
  parameter logic [DW-1:0] MARK_G      = '0,
  parameter logic [DW-1:0] MARK_B      = '0,
  parameter int            BLINK_LOG2  = 4
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iValid,
  input  logic [DW-1:0] iRed,
  input  logic [DW-1:0] iGreen,
  input  logic [DW-1:0] iBlue,
  input  logic [PW-1:0] iXposition,
  input  logic [PW-1:0] iYposition,
  input  logic          iFrameStart,
  input  logic [PW-1:0] iXresult,
  input  logic [PW-1:0] iYresult,
  input  logic          iFinished,
  input  logic [1:0]    iMode,
  input  logic [DW-1:0] iThreshold,
  output logic          oValid,
  output logic [DW-1:0] oRed,
  output logic [DW-1:0] oGreen,
  output logic [DW-1:0] oBlue,
  output logic [PW-1:0] oXposition,
  output logic [PW-1:0] oYposition
);

  typedef struct packed {
    mode_e         mode;
    logic [DW-1:0] thr;
    logic [DW-1:0] red;
    logic [DW-1:0] green;
    logic [DW-1:0] blue;
    logic [PW-1:0] xpos;
    logic [PW-1:0] ypos;
    logic          mark;
  } side_t;

  logic [PW-1:0]         pos_x_q, pos_x_d;
  logic [PW-1:0]         pos_y_q, pos_y_d;
  logic                  have_q, have_d;
  logic                  stale_q, stale_d;
  logic [BLINK_LOG2-1:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    have_d      = have_q;
    stale_d     = stale_q;
    frame_cnt_d = frame_cnt_q;
    if (iFrameStart) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
      if (iFinished) begin
        pos_x_d = iXresult + PW'(H_OFFSET);
        pos_y_d = iYresult + PW'(V_OFFSET);
        have_d  = 1'b1;
        stale_d = 1'b0;
      end else if (have_q) begin
        stale_d = 1'b1;
      end
    end
  end

  // One extra bit so a marker near the right/bottom edge does not wrap to column/row 0.
  logic [PW:0] x_ext, y_ext, px_ext, py_ext;
  logic        hit, mark;

  assign x_ext  = {1'b0, iXposition};
  assign y_ext  = {1'b0, iYposition};
  assign px_ext = {1'b0, pos_x_q};
  assign py_ext = {1'b0, pos_y_q};
  assign hit    = (x_ext >= px_ext) && (x_ext < px_ext + (PW+1)'(SQUARE_SIZE)) &&
                  (y_ext >= py_ext) && (y_ext < py_ext + (PW+1)'(SQUARE_SIZE));
  assign mark   = have_q & hit & (~stale_q | frame_cnt_q[BLINK_LOG2-1]);

  logic  s1_vld_q;
  side_t s1_q, s1_d;
  side_t s2_q, s2_d;
  logic  s2_vld;
  logic [DW-1:0] luma;

  always_comb begin
    s1_d = s1_q;
    if (iValid) begin
      s1_d.mode  = mode_e'(iMode);
      s1_d.thr   = iThreshold;
      s1_d.red   = iRed;
      s1_d.green = iGreen;
      s1_d.blue  = iBlue;
      s1_d.xpos  = iXposition;
      s1_d.ypos  = iYposition;
      s1_d.mark  = mark;
    end
  end

  always_comb begin
    s2_d = s2_q;
    if (s1_vld_q) s2_d = s1_q;
  end

  luma_calc #(
    .DW(DW)
  ) u_luma (
    .clk      (iCLK),
    .rst_n    (iRST),
    .in_vld   (iValid),
    .in_red   (iRed),
    .in_green (iGreen),
    .in_blue  (iBlue),
    .out_vld  (s2_vld),
    .out_luma (luma)
  );

  logic          out_vld_q;
  logic [DW-1:0] out_r_q, out_r_d, out_g_q, out_g_d, out_b_q, out_b_d;
  logic [PW-1:0] out_x_q, out_x_d, out_y_q, out_y_d;
  logic [DW-1:0] bin_lvl;

  assign bin_lvl = (luma >= s2_q.thr) ? {DW{1'b1}} : {DW{1'b0}};

  always_comb begin
    out_r_d = out_r_q;
    out_g_d = out_g_q;
    out_b_d = out_b_q;
    out_x_d = out_x_q;
    out_y_d = out_y_q;
    if (s2_vld) begin
      case (s2_q.mode)
        MODE_PASS: begin
          out_r_d = s2_q.red;
          out_g_d = s2_q.green;
          out_b_d = s2_q.blue;
        end
        MODE_GRAY: begin
          out_r_d = luma;
          out_g_d = luma;
          out_b_d = luma;
        end
        MODE_BIN: begin
          out_r_d = bin_lvl;
          out_g_d = bin_lvl;
          out_b_d = bin_lvl;
        end
        MODE_INV: begin
          out_r_d = {DW{1'b1}} - luma;
          out_g_d = {DW{1'b1}} - luma;
          out_b_d = {DW{1'b1}} - luma;
        end
      endcase
      if (s2_q.mark) begin
        out_r_d = MARK_R;
        out_g_d = MARK_G;
        out_b_d = MARK_B;
      end
      out_x_d = s2_q.xpos;
      out_y_d = s2_q.ypos;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      pos_x_q     <= '0;
      pos_y_q     <= '0;
      have_q      <= 1'b0;
      stale_q     <= 1'b0;
      frame_cnt_q <= '0;
      s1_vld_q    <= 1'b0;
      s1_q        <= '0;
      s2_q        <= '0;
      out_vld_q   <= 1'b0;
      out_r_q     <= '0;
      out_g_q     <= '0;
      out_b_q     <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
    end else begin
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      have_q      <= have_d;
      stale_q     <= stale_d;
      frame_cnt_q <= frame_cnt_d;
      s1_vld_q    <= iValid;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      out_vld_q   <= s2_vld;
      out_r_q     <= out_r_d;
      out_g_q     <= out_g_d;
      out_b_q     <= out_b_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
    end
  end

  assign oValid     = out_vld_q;
  assign oRed       = out_r_q;
  assign oGreen     = out_g_q;
  assign oBlue      = out_b_q;
  assign oXposition = out_x_q;
  assign oYposition = out_y_q;

endmodule

// File: tb/tb_pixel_luma_overlay.sv
// Directed and randomized stimulus for pixel_luma_overlay against a per-pixel reference model.
module tb_pixel_luma_overlay;

  localparam int DW  = 10;
  localparam int PW  = 13;
  localparam int SQ  = 5;
  localparam int HOF = 100;
  localparam int VOF = 50;
  localparam int BL  = 1;
  localparam int FULL = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vld, fs, fin;
  logic [DW-1:0] r, g, b, thr;
  logic [PW-1:0] x, y, xr, yr;
  logic [1:0]    mode;
  logic          o_vld;
  logic [DW-1:0] o_r, o_g, o_b;
  logic [PW-1:0] o_x, o_y;

  always #5 clk = ~clk;

  pixel_luma_overlay #(
    .DW(DW), .PW(PW), .SQUARE_SIZE(SQ), .H_OFFSET(HOF), .V_OFFSET(VOF), .BLINK_LOG2(BL)
  ) dut (
    .iCLK(clk), .iRST(rst_n), .iValid(vld),
    .iRed(r), .iGreen(g), .iBlue(b),
    .iXposition(x), .iYposition(y),
    .iFrameStart(fs), .iXresult(xr), .iYresult(yr), .iFinished(fin),
    .iMode(mode), .iThreshold(thr),
    .oValid(o_vld), .oRed(o_r), .oGreen(o_g), .oBlue(o_b),
    .oXposition(o_x), .oYposition(o_y)
  );

  typedef struct {
    bit v;
    int r, g, b, x, y;
  } pix_t;

  pix_t pipe[3];
  pix_t last;
  int   m_have, m_stale, m_fc, m_px, m_py;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic pix_t model(int rr, int gg, int bb, int xx, int yy, int md, int th);
    pix_t p;
    int   ly;
    ly = (77 * rr + 150 * gg + 29 * bb) / 256;
    if (ly > FULL) ly = FULL;
    p.v = 1'b1;
    p.x = xx;
    p.y = yy;
    case (md)
      0: begin p.r = rr; p.g = gg; p.b = bb; end
      1: begin p.r = ly; p.g = ly; p.b = ly; end
      2: begin p.r = (ly >= th) ? FULL : 0; p.g = p.r; p.b = p.r; end
      default: begin p.r = FULL - ly; p.g = p.r; p.b = p.r; end
    endcase
    if (m_have != 0 && xx >= m_px && xx < m_px + SQ && yy >= m_py && yy < m_py + SQ &&
        (m_stale == 0 || ((m_fc >> (BL - 1)) & 1) == 1)) begin
      p.r = FULL; p.g = 0; p.b = 0;
    end
    return p;
  endfunction

  task automatic check_outputs(string tag);
    check({tag, ".oValid"}, 32'(o_vld), 32'(pipe[2].v));
    if (pipe[2].v) last = pipe[2];
    check({tag, ".oRed"},   32'(o_r), 32'(last.r));
    check({tag, ".oGreen"}, 32'(o_g), 32'(last.g));
    check({tag, ".oBlue"},  32'(o_b), 32'(last.b));
    check({tag, ".oX"},     32'(o_x), 32'(last.x));
    check({tag, ".oY"},     32'(o_y), 32'(last.y));
  endtask

  task automatic step(string tag, bit v, int rr, int gg, int bb, int xx, int yy, int md, int th,
                      bit f = 1'b0, bit fi = 1'b0, int xres = 0, int yres = 0);
    pix_t p;
    p = '{default: 0};
    vld = v; r = DW'(rr); g = DW'(gg); b = DW'(bb);
    x = PW'(xx); y = PW'(yy); mode = 2'(md); thr = DW'(th);
    fs = f; fin = fi; xr = PW'(xres); yr = PW'(yres);
    if (v) p = model(rr, gg, bb, xx, yy, md, th);
    if (f) begin
      m_fc = (m_fc + 1) % (1 << BL);
      if (fi) begin
        m_px = (xres + HOF) % (1 << PW);
        m_py = (yres + VOF) % (1 << PW);
        m_have = 1; m_stale = 0;
      end else if (m_have != 0) begin
        m_stale = 1;
      end
    end
    @(posedge clk); #1;
    pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = p;
    check_outputs(tag);
  endtask

  task automatic idle(string tag, int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
    last = '{default: 0};
    m_have = 0; m_stale = 0; m_fc = 0; m_px = 0; m_py = 0;
  endtask

  initial begin
    rst_n = 1'b0; vld = 0; fs = 0; fin = 0; r = 0; g = 0; b = 0; thr = 0;
    x = 0; y = 0; xr = 0; yr = 0; mode = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rst_n = 1'b1;

    // Saturation corner and red-only luma
    step("sat", 1, 1023, 1023, 1023, 1, 1, 1, 0);
    step("red400", 1, 400, 0, 0, 2, 1, 1, 0);
    idle("flush1", 3);

    // Threshold boundary, back-to-back, then per-pixel mode switches
    step("thr511", 1, 511, 511, 511, 3, 1, 2, 512);
    step("thr512", 1, 512, 512, 512, 4, 1, 2, 512);
    step("sw_gray", 1, 300, 700, 90, 5, 1, 1, 512);
    step("sw_gray", 1, 800, 100, 900, 6, 1, 1, 512);
    step("sw_pass", 1, 300, 700, 90, 7, 1, 0, 512);
    step("sw_pass", 1, 800, 100, 900, 8, 1, 0, 512);
    step("sw_inv", 1, 800, 100, 900, 9, 1, 3, 512);
    idle("flush2", 3);

    // Marker latched at (110,70); scan its neighbourhood
    step("latch", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 10, 20);
    for (int yy = 69; yy <= 75; yy++)
      for (int xx = 108; xx <= 116; xx++)
        step("scan", 1, 300, 300, 300, xx, yy, 1, 0);
    idle("flush3", 3);

    // Stale result blinks, then a fresh result is steady
    for (int f = 0; f < 4; f++) begin
      step("stale_fs", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step("stale_in", 1, 200, 200, 200, 112, 72, 1, 0);
      step("stale_out", 1, 200, 200, 200, 120, 72, 1, 0);
    end
    for (int f = 0; f < 3; f++) begin
      step("fresh_fs", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 10, 20);
      step("fresh_in", 1, 200, 200, 200, 112, 72, 1, 0);
    end
    // Same-cycle pixel uses the old position
    step("same_cyc", 1, 200, 200, 200, 112, 72, 1, 0, 1, 1, 0, 0);
    step("new_pos", 1, 200, 200, 200, 112, 72, 1, 0);
    step("new_pos2", 1, 200, 200, 200, 102, 52, 1, 0);
    idle("flush4", 3);

    // Valid gaps
    step("gap", 1, 10, 20, 30, 1, 2, 0, 0);
    idle("gap", 2);
    step("gap", 1, 40, 50, 60, 3, 4, 0, 0);
    idle("gap", 4);

    // Randomized traffic around the marker with occasional frame starts
    for (int i = 0; i < 400; i++)
      step("rand", ($urandom_range(0, 3) != 0), int'($urandom_range(0, FULL)),
           int'($urandom_range(0, FULL)), int'($urandom_range(0, FULL)),
           int'($urandom_range(95, 120)), int'($urandom_range(60, 80)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, FULL)),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 1) == 1),
           int'($urandom_range(0, 15)), int'($urandom_range(12, 25)));
    idle("flush5", 3);

    // Re-latch at (110,70), put 3 pixels in flight, then reset asynchronously
    step("relatch", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 10, 20);
    step("flight", 1, 500, 500, 500, 112, 72, 1, 0);
    step("flight", 1, 600, 600, 600, 113, 72, 1, 0);
    step("flight", 1, 700, 700, 700, 114, 72, 1, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(posedge clk); #1;
    check_outputs("rst_hold");
    rst_n = 1'b1;
    step("post_rst", 1, 250, 250, 250, 112, 72, 1, 0);
    step("post_rst_fs0", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("post_rst", 1, 250, 250, 250, 112, 72, 1, 0);
    step("post_rst_fs1", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 10, 20);
    step("post_rst", 1, 250, 250, 250, 112, 72, 1, 0);
    idle("flush6", 4);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
